// File: rtl/demux32_deser_pkg.sv
// -----------------------------------------------------------------------------
// demux32_deser_pkg
// Shared constants, types and helpers for the serial-to-parallel capture block.
//   XLEN        : assembled word width (32)
//   IDXW        : bit-position counter width (5)
//   buf_state_e : one-entry output buffer occupancy (EMPTY / FULL)
//   start_idx() : position of the first bit of a word for a given bit order
//   last_idx()  : position of the final bit of a word for a given bit order
// -----------------------------------------------------------------------------
package demux32_deser_pkg;

    localparam int XLEN = 32;
    localparam int IDXW = 5;

    // Buffer occupancy; the encoding doubles as out_valid.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    function automatic logic [IDXW-1:0] start_idx(input bit msb_first);
        return msb_first ? IDXW'(XLEN - 1) : '0;
    endfunction

    function automatic logic [IDXW-1:0] last_idx(input bit msb_first);
        return msb_first ? '0 : IDXW'(XLEN - 1);
    endfunction

endpackage

// File: rtl/demux32_deser_decoder5t32.sv
// -----------------------------------------------------------------------------
// decoder5t32
// Combinational 5-to-32 one-hot decoder. Produces the per-bit write enables
// that steer a serial bit into the accumulator; it is the write-side partner
// of the 32:1 bit-select mux.
// Ports:
//   sel    : in  [IDXW-1:0]  bit position
//   onehot : out [XLEN-1:0]  one-hot enable, bit sel set
// -----------------------------------------------------------------------------
module decoder5t32
    import demux32_deser_pkg::*;
(
    input  logic [IDXW-1:0] sel,
    output logic [XLEN-1:0] onehot
);

    assign onehot = {{(XLEN-1){1'b0}}, 1'b1} << sel;

endmodule

// File: rtl/demux32_deser.sv
// -----------------------------------------------------------------------------
// demux32_deser
// Serial-to-parallel capture: each accepted serial bit is written into the
// accumulator at position idx; a completed word moves into a one-entry output
// buffer drained with a valid/ready handshake.
// Parameters:
//   T         : unit gate delay for behavioural delay modelling (outputs are
//               delay-free in this implementation)
//   MSB_FIRST : 0 -> first bit lands in bit 0, idx counts up
//               1 -> first bit lands in bit 31, idx counts down
// Ports:
//   clk       : in   rising-edge clock
//   rstn      : in   asynchronous active-low reset
//   clr       : in   synchronous restart of the partial word (buffer kept)
//   in_valid  : in   in_bit is valid this cycle
//   in_bit    : in   serial data bit
//   in_ready  : out  block accepts in_bit this cycle
//   out_valid : out  out_word holds a complete word
//   out_ready : in   consumer takes out_word this cycle
//   out_word  : out  [31:0] assembled word
//   idx       : out  [4:0]  position the next accepted bit will occupy
//   overrun   : out  sticky: a word completed while the buffer was blocked
// -----------------------------------------------------------------------------
module demux32_deser
    import demux32_deser_pkg::*;
#(
    parameter real T         = 0.0,
    parameter bit  MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr,
    input  logic            in_valid,
    input  logic            in_bit,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_word,
    output logic [IDXW-1:0] idx,
    output logic            overrun
);

    localparam logic [IDXW-1:0] IDX_START = start_idx(MSB_FIRST);
    localparam logic [IDXW-1:0] IDX_LAST  = last_idx(MSB_FIRST);

    // A negative gate delay has no meaning; nothing is elaborated otherwise.
    if (T < 0.0) begin : g_t_negative
    end

    logic [XLEN-1:0] acc_q, acc_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [XLEN-1:0] out_word_q, out_word_d;
    logic            overrun_q, overrun_d;
    buf_state_e      state_q, state_d;

    logic [XLEN-1:0] wr_en;
    logic [XLEN-1:0] acc_wr;
    logic            last;
    logic            pop;
    logic            accept;
    logic            complete;

    decoder5t32 u_dec (
        .sel    (idx_q),
        .onehot (wr_en)
    );

    assign last     = (idx_q == IDX_LAST);
    assign pop      = (state_q == BUF_FULL) & out_ready;
    // Only the final bit of a word ever stalls: it alone needs the buffer.
    assign in_ready = !(last & (state_q == BUF_FULL) & !out_ready);
    // clr wins over a bit presented on the same cycle.
    assign accept   = in_valid & in_ready & !clr;
    assign complete = accept & last;
    // Accumulator with the current bit merged in; this is the finished word
    // when the current bit is the last one.
    assign acc_wr   = (acc_q & ~wr_en) | (wr_en & {XLEN{in_bit}});

    // Buffer occupancy next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BUF_EMPTY: if (complete)        state_d = BUF_FULL;
            BUF_FULL:  if (pop && !complete) state_d = BUF_EMPTY;
            default:                        state_d = BUF_EMPTY;
        endcase
    end

    // Counter, accumulator, buffered word and overrun flag.
    always_comb begin
        acc_d      = acc_q;
        idx_d      = idx_q;
        out_word_d = out_word_q;
        overrun_d  = overrun_q;
        if (clr) begin
            acc_d     = '0;
            idx_d     = IDX_START;
            overrun_d = 1'b0;
        end else if (accept) begin
            if (last) begin
                out_word_d = acc_wr;
                acc_d      = '0;
                idx_d      = IDX_START;
                // Unreachable while in_ready gates the last bit; kept as a
                // protocol-checker hook.
                if ((state_q == BUF_FULL) && !out_ready) begin
                    overrun_d = 1'b1;
                end
            end else begin
                acc_d = acc_wr;
                idx_d = MSB_FIRST ? (idx_q - 5'd1) : (idx_q + 5'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q      <= '0;
            idx_q      <= IDX_START;
            out_word_q <= '0;
            overrun_q  <= 1'b0;
            state_q    <= BUF_EMPTY;
        end else begin
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            out_word_q <= out_word_d;
            overrun_q  <= overrun_d;
            state_q    <= state_d;
        end
    end

    assign out_valid = (state_q == BUF_FULL);
    assign out_word  = out_word_q;
    assign idx       = idx_q;
    assign overrun   = overrun_q;

endmodule
